serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder cell (one-bit sum/carry slice, instantiated or equivalent logic) plus a carry flip-flop.
- Feeds the full adder one operand bit pair per clock, LSB first, and accumulates the sum bits into a result register.
- Sits directly upstream of the full-adder cell as its sequencing stage; trades WIDTH cycles of latency for one adder slice.

Parameters:
- WIDTH, 8, operand and sum width in bits (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset: one clock with rst=1 → state IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry and counter cleared. rst has priority over all other inputs in every state.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at edge E0 → load A_sh=a, B_sh=b, carry=cin, cnt=0, state→SHIFT, busy=1. Otherwise hold; sum/cout keep their last result.
- SHIFT: each edge computes s = A_sh[0]^B_sh[0]^carry and c = majority(A_sh[0], B_sh[0], carry).
  - Shift s into MSB of an internal accumulator (shift right).
  - Shift A_sh and B_sh right by 1; carry=c; cnt=cnt+1.
  - On the edge where cnt=WIDTH-1 (edge E0+WIDTH): sum←final accumulator including this bit, cout←c, state→DONE, busy=0, done=1.
- DONE: lasts exactly one cycle; done=0 and state→IDLE on the next edge. start during DONE is ignored.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after the accepting edge. Throughput is one addition per WIDTH+2 cycles minimum.
- start while busy (SHIFT) is ignored. Operand inputs are not sampled after E0, so changes to a/b/cin mid-operation have no effect.
- sum/cout update only at completion and stay stable during busy, holding the previous result.
- Arithmetic: {cout,sum} = a + b + cin exactly, WIDTH+1 bits, no saturation; wrap-around is expressed by cout.
- cnt width is clog2(WIDTH) bits minimum and never exceeds WIDTH-1.
- Reset mid-operation: abort immediately; no done pulse; sum=0, cout=0, busy=0 after the reset edge.
- start held high continuously: new operation accepted in each IDLE cycle, so one addition starts every WIDTH+2 cycles.

Test Plan (WIDTH=8, start pulsed 1 cycle, checks taken in the done cycle):
- a=0x00, b=0x00, cin=0 → done exactly 8 cycles after the accepting edge; sum=0x00, cout=0; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1 (full carry ripple through all bits).
- a=0x5A, b=0x3C, cin=1 → sum=0x97, cout=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Previous result must hold during the second operation's busy window.
- During an active add of 0x12+0x34 (cin=0), pulse start with a=0xFF, b=0xFF at shift cycle 3 and change a/b → ignored; result sum=0x46, cout=0, only one done pulse.
- Assert rst for one cycle at shift cycle 4 of 0x80+0x80 → busy=0, sum=0x00, cout=0, no done pulse. A following 0x80+0x80 (cin=0) gives sum=0x00, cout=1.
- Exhaustive check: all 8 (a[0], b[0], cin) combinations with upper bits zero, run back-to-back with start held high → {cout,sum} equals the reference sum each time; one done per operation, spaced 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the request and operands; the slave returns status and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first.
// The result takes WIDTH shift cycles; sum/cout change only when an addition completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [1:0]       fa_out;
    logic             last_bit;

    // One-bit full-adder slice: {carry, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    assign fa_out   = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == IDLE && bus.start) begin
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            // Sum bits enter at the MSB so the LSB-first stream lands in order after WIDTH shifts
            acc_d   = {fa_out[0], acc_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_out[1];
            cnt_d   = cnt_q + 1'b1;
            if (last_bit) begin
                sum_d  = {fa_out[0], acc_q[WIDTH-1:1]};
                cout_d = fa_out[1];
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8: latency, carry ripple, result hold,
// ignored start, reset abort and back-to-back operation with start held high.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   cyc_now = 0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; bounded so a missing done cannot hang the run
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
            if (bus.busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
        total++; if (bus.sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", bus.cout); else passed++;
    endtask

    task automatic test_zero();
        int cyc, bc;
        tick();
        start_op(8'h00, 8'h00, 1'b0);
        wait_done(cyc, bc);
        total++; if (cyc !== 8) $display("FAIL zero_latency got=%0d exp=8", cyc); else passed++;
        total++; if (bc !== 8) $display("FAIL zero_busy_cycles got=%0d exp=8", bc); else passed++;
        total++; if (bus.sum !== 8'h00) $display("FAIL zero_sum got=%h exp=00", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b0) $display("FAIL zero_cout got=%b exp=0", bus.cout); else passed++;
        tick();
        total++; if (bus.done !== 1'b0) $display("FAIL zero_done_width got=%b exp=0", bus.done); else passed++;
    endtask

    task automatic test_ripple();
        int cyc, bc;
        tick();
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bc);
        total++; if (cyc !== 8) $display("FAIL ripple_latency got=%0d exp=8", cyc); else passed++;
        total++; if (bus.sum !== 8'h00) $display("FAIL ripple_sum got=%h exp=00", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b1) $display("FAIL ripple_cout got=%b exp=1", bus.cout); else passed++;
        tick();
    endtask

    task automatic test_hold();
        int cyc, bc;
        logic held;
        tick();
        start_op(8'h5A, 8'h3C, 1'b1);
        wait_done(cyc, bc);
        total++; if (bus.sum !== 8'h97) $display("FAIL hold_first_sum got=%h exp=97", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b0) $display("FAIL hold_first_cout got=%b exp=0", bus.cout); else passed++;
        tick(); tick();
        start_op(8'hFF, 8'hFF, 1'b1);
        held = 1'b1;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 30) begin
            if (bus.sum !== 8'h97 || bus.cout !== 1'b0) held = 1'b0;
            tick();
            cyc++;
        end
        total++; if (held !== 1'b1) $display("FAIL hold_during_busy got=%b exp=1", held); else passed++;
        total++; if (bus.sum !== 8'hFF) $display("FAIL hold_second_sum got=%h exp=ff", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b1) $display("FAIL hold_second_cout got=%b exp=1", bus.cout); else passed++;
        tick();
    endtask

    task automatic test_start_ignored();
        int cyc, bc, extra;
        tick();
        start_op(8'h12, 8'h34, 1'b0);
        tick(); tick();
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc, bc);
        total++; if (cyc !== 5) $display("FAIL ignored_latency got=%0d exp=5", cyc); else passed++;
        total++; if (bus.sum !== 8'h46) $display("FAIL ignored_sum got=%h exp=46", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b0) $display("FAIL ignored_cout got=%b exp=0", bus.cout); else passed++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) extra++;
        end
        total++; if (extra !== 0) $display("FAIL ignored_extra_done got=%0d exp=0", extra); else passed++;
    endtask

    task automatic test_rst_abort();
        int cyc, bc, dn;
        tick();
        start_op(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy); else passed++;
        total++; if (bus.sum !== 8'h00) $display("FAIL abort_sum got=%h exp=00", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b0) $display("FAIL abort_cout got=%b exp=0", bus.cout); else passed++;
        dn = (bus.done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) dn++;
        end
        total++; if (dn !== 0) $display("FAIL abort_done_pulses got=%0d exp=0", dn); else passed++;
        start_op(8'h80, 8'h80, 1'b0);
        wait_done(cyc, bc);
        total++; if (cyc !== 8) $display("FAIL abort_next_latency got=%0d exp=8", cyc); else passed++;
        total++; if (bus.sum !== 8'h00) $display("FAIL abort_next_sum got=%h exp=00", bus.sum); else passed++;
        total++; if (bus.cout !== 1'b1) $display("FAIL abort_next_cout got=%b exp=1", bus.cout); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc, last_done;
        logic [2:0] combo;
        logic [8:0] exp9;
        logic [8:0] got9;
        tick();
        combo = 3'd0;
        bus.a = 8'(combo[2]); bus.b = 8'(combo[1]); bus.cin = combo[0];
        bus.start = 1'b1;
        tick();
        last_done = 0;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            exp9 = 9'(combo[2]) + 9'(combo[1]) + 9'(combo[0]);
            if (i < 7) begin
                combo = 3'(i + 1);
                bus.a = 8'(combo[2]); bus.b = 8'(combo[1]); bus.cin = combo[0];
            end else begin
                bus.start = 1'b0;
            end
            wait_done(cyc, bc);
            got9 = {bus.cout, bus.sum};
            total++; if (got9 !== exp9) $display("FAIL b2b_result op=%0d got=%h exp=%h", i, got9, exp9); else passed++;
            total++; if (cyc !== 8) $display("FAIL b2b_latency op=%0d got=%0d exp=8", i, cyc); else passed++;
            if (i > 0) begin
                total++;
                if (cyc_now - last_done !== 10) $display("FAIL b2b_spacing op=%0d got=%0d exp=10", i, cyc_now - last_done);
                else passed++;
            end
            last_done = cyc_now;
            tick();
            tick();
        end
        total++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle_after got=%b exp=0", bus.busy); else passed++;
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        test_reset();
        test_zero();
        test_ripple();
        test_hold();
        test_start_ignored();
        test_rst_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
